// File: rtl/fp32_divider.sv
// rtl/fp32_divider.sv - iterative binary32 divider, one restoring quotient bit per cycle
module fp32_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

   state_t            state;
   state_t            state_next;

   logic              sign;
   logic signed [9:0] exp_q;
   logic [24:0]       rem;
   logic [23:0]       dvs;
   logic [24:0]       q;
   logic [4:0]        count;

   logic              accept;
   logic [7:0]        exp_a;
   logic [7:0]        exp_b;
   logic              sign_in;
   logic signed [9:0] exp_in;
   logic              special;
   logic [31:0]       special_result;

   logic              ge;
   logic [24:0]       rem_sub;
   logic [24:0]       rem_next;

   logic signed [9:0] exp_norm;
   logic [22:0]       mant_norm;
   logic [31:0]       norm_result;

   assign accept  = in_valid && in_ready;
   assign exp_a   = dividend[30:23];
   assign exp_b   = divisor[30:23];
   assign sign_in = dividend[31] ^ divisor[31];
   assign exp_in  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;

   // Special operands bypass the iteration entirely; order sets precedence.
   always_comb begin
      special        = 1'b1;
      special_result = {sign_in, 31'h0};
      if (exp_b == 8'd0) begin
         special_result = {sign_in, 8'hFF, 23'h0};
      end else if (exp_a == 8'hFF) begin
         special_result = {sign_in, 8'hFF, 23'h0};
      end else if (exp_a == 8'd0) begin
         special_result = {sign_in, 31'h0};
      end else if (exp_b == 8'hFF) begin
         special_result = {sign_in, 31'h0};
      end else begin
         special = 1'b0;
      end
   end

   // Partial remainder stays below 2*D, so bit 24 is free to drop on the shift.
   assign ge       = rem >= {1'b0, dvs};
   assign rem_sub  = rem - {1'b0, dvs};
   assign rem_next = ge ? {rem_sub[23:0], 1'b0} : {rem[23:0], 1'b0};

   always_comb begin
      exp_norm  = q[24] ? exp_q : exp_q - 10'sd1;
      mant_norm = q[24] ? q[23:1] : q[22:0];
      if (exp_norm >= 10'sd255) begin
         norm_result = {sign, 8'hFF, 23'h0};
      end else if (exp_norm <= 10'sd0) begin
         norm_result = {sign, 31'h0};
      end else begin
         norm_result = {sign, exp_norm[7:0], mant_norm};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (count == 5'd24) begin
               state_next = NORM;
            end
         end
         NORM: state_next = DONE;
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign     <= 1'b0;
         exp_q    <= 10'sd0;
         rem      <= 25'h0;
         dvs      <= 24'h0;
         q        <= 25'h0;
         count    <= 5'd0;
         quotient <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign  <= sign_in;
                  exp_q <= exp_in;
                  rem   <= {2'b01, dividend[22:0]};
                  dvs   <= {1'b1, divisor[22:0]};
                  q     <= 25'h0;
                  count <= 5'd0;
                  if (special) begin
                     quotient <= special_result;
                  end
               end
            end
            CALC: begin
               rem   <= rem_next;
               q     <= {q[23:0], ge};
               count <= count + 5'd1;
            end
            NORM: quotient <= norm_result;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_divider.sv
// tb/tb_fp32_divider.sv - randomized self-checking bench for fp32_divider
module tb_fp32_divider;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = 32'h0;
   logic [31:0] divisor = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quotient;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          rand_ready = 1'b0;

   logic [32:0] pend_q[$];
   bit          in_flight = 1'b0;
   int          acc_edge = 0;
   int          lat_exp = 0;
   logic [31:0] held = 32'h0;
   bit          chk_reset = 1'b0;

   fp32_divider dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: {special, result}; quotient taken as floor(ma * 2^24 / mb).
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea, eb, e;
      longint      ma, mb, qq;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0)   return {1'b1, s, 8'hFF, 23'h0};
      if (ea == 255) return {1'b1, s, 8'hFF, 23'h0};
      if (ea == 0)   return {1'b1, s, 31'h0};
      if (eb == 255) return {1'b1, s, 31'h0};
      ma = 64'(a[22:0]) + 64'h800000;
      mb = 64'(b[22:0]) + 64'h800000;
      qq = (ma * 64'h1000000) / mb;
      e  = ea - eb + 127;
      if (qq >= 64'h1000000) begin
         m = 23'(qq / 2);
      end else begin
         m = 23'(qq);
         e = e - 1;
      end
      if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
      if (e <= 0)   return {1'b0, s, 31'h0};
      return {1'b0, s, 8'(e), m};
   endfunction

   always @(negedge clk) begin
      logic [32:0] r;
      if (chk_reset && !rst) begin
         check("reset_in_ready", in_ready, 1);
         check("reset_out_valid", out_valid, 0);
         check("reset_quotient", quotient, 0);
         chk_reset = 1'b0;
      end
      if (rst) begin
         in_flight = 1'b0;
         pend_q.delete();
         held = 32'h0;
         chk_reset = 1'b1;
      end else begin
         check("in_ready", in_ready, !in_flight);
         check("busy", busy, in_flight);
         check("out_valid", out_valid, in_flight && (cyc - acc_edge >= lat_exp));
         if (out_valid && pend_q.size() > 0) begin
            check("quotient", quotient, pend_q[0][31:0]);
            held = pend_q[0][31:0];
            if (out_ready) begin
               void'(pend_q.pop_front());
               in_flight = 1'b0;
            end
         end else if (!out_valid) begin
            check("quotient_hold", quotient, held);
         end
         if (in_valid && in_ready) begin
            r = model(dividend, divisor);
            pend_q.push_back(r);
            acc_edge = cyc + 1;
            lat_exp = r[32] ? 0 : 26;
            in_flight = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, output int waited);
      bit got;
      got = 1'b0;
      waited = 0;
      dividend = a;
      divisor = b;
      in_valid = 1'b1;
      while (!got && waited < 200) begin
         @(negedge clk);
         got = in_ready;
         tick();
         waited++;
      end
      in_valid = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (in_flight && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (in_flight) begin
         errors++;
         $display("FAIL drain_timeout: got in_flight=1 expected 0 after %0d cycles", n);
      end
   endtask

   function automatic logic [31:0] rand_op();
      int          sel;
      logic [7:0]  e;
      sel = $urandom_range(0, 15);
      case (sel)
         0:       e = 8'd0;
         1:       e = 8'hFF;
         2:       e = 8'($urandom_range(250, 254));
         3:       e = 8'($urandom_range(1, 5));
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   logic [31:0] dir_a[10] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h3F800000, 32'h80000000,
                              32'h40000000, 32'h7F000000, 32'h00800000, 32'h41200000, 32'h7F800000};
   logic [31:0] dir_b[10] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h40000000,
                              32'h7F800000, 32'h3E800000, 32'h40000000, 32'h40A00000, 32'h00000000};
   logic [31:0] dir_r[10] = '{32'h40400000, 32'h3EAAAAAA, 32'hC1800000, 32'h7F800000, 32'h80000000,
                              32'h00000000, 32'h7F800000, 32'h00000000, 32'h40000000, 32'h7F800000};

   initial begin
      int w;
      logic [32:0] r;
      repeat (3) tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         r = model(dir_a[i], dir_b[i]);
         check($sformatf("model_pin_%0d", i), r[31:0], dir_r[i]);
      end

      for (int i = 0; i < 10; i++) begin
         send(dir_a[i], dir_b[i], w);
         drain();
      end

      out_ready = 1'b0;
      send(32'h40C00000, 32'h40000000, w);
      for (int n = 0; n < 60 && !out_valid; n++) tick();
      repeat (10) tick();
      out_ready = 1'b1;
      send(32'h41200000, 32'h40A00000, w);
      check("bp_accept_edges", w, 2);
      drain();

      send(32'h40C00000, 32'h40000000, w);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send(32'h41200000, 32'h40A00000, w);
      drain();

      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(rand_op(), rand_op(), w);
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain();
      rand_ready = 1'b0;
      out_ready = 1'b1;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end
endmodule
